// File: rtl/mbldcm_phase_sequencer_if.sv
// mbldcm_phase_sequencer_if
// Control/status bundle between the commutation phase sequencer and its driver.
//   enable      1 = stepping allowed, 0 = hold phase and clear period counter
//   dir         0 = forward (increment), 1 = reverse (decrement)
//   period      clocks per phase step, 0 = no stepping
//   load        synchronous phase load strobe
//   load_phase  phase value applied on load
//   phase       current commutation phase (registered)
//   step        one-cycle strobe in the first cycle phase shows a stepped value
//   running     registered run status
//   rev_cnt     signed electrical revolution counter
//               (only with MBLDCM_PHASE_SEQUENCER_REVCNT_EN)
// Modports: master = controller side, slave = sequencer side.
interface mbldcm_phase_sequencer_if #(
  parameter int cnt_width = 16
);
  logic                 enable;
  logic                 dir;
  logic [cnt_width-1:0] period;
  logic                 load;
  logic [2:0]           load_phase;
  logic [2:0]           phase;
  logic                 step;
  logic                 running;
`ifdef MBLDCM_PHASE_SEQUENCER_REVCNT_EN
  logic signed [15:0]   rev_cnt;

  modport master (
    output enable, dir, period, load, load_phase,
    input  phase, step, running, rev_cnt
  );
  modport slave (
    input  enable, dir, period, load, load_phase,
    output phase, step, running, rev_cnt
  );
`else
  modport master (
    output enable, dir, period, load, load_phase,
    input  phase, step, running
  );
  modport slave (
    input  enable, dir, period, load, load_phase,
    output phase, step, running
  );
`endif
endinterface

// File: rtl/mbldcm_phase_sequencer.sv
// mbldcm_phase_sequencer
// Commutation phase generator for the BLDC drive. Steps a phase index through
// 0..total_phase_stages-1 every latched-period clocks, forward or reverse,
// with hold, synchronous load and a one-cycle step strobe.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  mbldcm_phase_sequencer_if.slave (enable, dir, period, load,
//        load_phase in; phase, step, running [, rev_cnt] out)
// Optional: define MBLDCM_PHASE_SEQUENCER_REVCNT_EN to add the 16-bit signed
// revolution counter bus.rev_cnt.
module mbldcm_phase_sequencer #(
  parameter int          cnt_width          = 16,
  parameter int unsigned total_phase_stages = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  mbldcm_phase_sequencer_if.slave       bus
);

  localparam logic [2:0]           last_phase = 3'(total_phase_stages - 1);
  localparam logic [3:0]           n_stages   = 4'(total_phase_stages);
  localparam logic [cnt_width-1:0] cnt_one    = cnt_width'(1);

  logic [cnt_width-1:0] r_period;
  logic [cnt_width-1:0] cnt;
  logic [2:0]           phase_q;
  logic [2:0]           phase_nxt;
  logic [2:0]           load_val;
  logic                 step_q;
  logic                 running_q;
  logic                 run;
  logic                 step_evt;

  assign run      = bus.enable && (r_period != '0);
  // Terminal count of the current phase; only meaningful while run (r_period != 0).
  assign step_evt = run && (cnt == (r_period - cnt_one));

  always_comb begin
    phase_nxt = phase_q;
    if (bus.dir) begin
      phase_nxt = (phase_q == 3'd0) ? last_phase : (phase_q - 3'd1);
    end else begin
      phase_nxt = (phase_q == last_phase) ? 3'd0 : (phase_q + 3'd1);
    end
  end

  // Out-of-range load values fall back to phase 0.
  assign load_val = ({1'b0, bus.load_phase} >= n_stages) ? 3'd0 : bus.load_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period  <= '0;
      cnt       <= '0;
      phase_q   <= 3'd0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      running_q <= run;
      // Period is only picked up between phases so a running phase keeps its length.
      if (!run || step_evt) begin
        r_period <= bus.period;
      end
      if (bus.load || !run || step_evt) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + cnt_one;
      end
      // Load wins over a coincident step; that step is dropped entirely.
      if (bus.load) begin
        phase_q <= load_val;
      end else if (step_evt) begin
        phase_q <= phase_nxt;
      end
      step_q <= step_evt && !bus.load;
    end
  end

  assign bus.phase   = phase_q;
  assign bus.step    = step_q;
  assign bus.running = running_q;

`ifdef MBLDCM_PHASE_SEQUENCER_REVCNT_EN
  logic signed [15:0] rev_cnt_q;
  logic               wrap_fwd;
  logic               wrap_rev;

  assign wrap_fwd = step_evt && !bus.load && !bus.dir && (phase_q == last_phase);
  assign wrap_rev = step_evt && !bus.load &&  bus.dir && (phase_q == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_cnt_q <= '0;
    end else if (wrap_fwd) begin
      rev_cnt_q <= rev_cnt_q + 16'sd1;
    end else if (wrap_rev) begin
      rev_cnt_q <= rev_cnt_q - 16'sd1;
    end
  end

  assign bus.rev_cnt = rev_cnt_q;
`endif

endmodule

// File: tb/tb_mbldcm_phase_sequencer.sv
module tb_mbldcm_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [2:0] phase;
    int         cyc;
    int         rev;
  } exp_t;

  exp_t q[$];
  exp_t e;

  mbldcm_phase_sequencer_if #(.cnt_width(16)) sif ();

  mbldcm_phase_sequencer #(
    .cnt_width(16),
    .total_phase_stages(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [2:0] p, input int c, input int r);
    exp_t x;
    x.phase = p;
    x.cyc   = c;
    x.rev   = r;
    q.push_back(x);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every step strobe is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && sif.step) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step actual_phase=%0d cyc=%0d required=no_step", sif.phase, cyc);
      end else begin
        e = q.pop_front();
        chk("step_phase", int'(sif.phase), int'(e.phase));
        chk("step_cycle", cyc, e.cyc);
`ifdef MBLDCM_PHASE_SEQUENCER_REVCNT_EN
        chk("step_rev", int'(sif.rev_cnt), e.rev);
`endif
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d;
    int r;
    sif.enable     = 1'b0;
    sif.dir        = 1'b0;
    sif.period     = '0;
    sif.load       = 1'b0;
    sif.load_phase = 3'd0;

    #2;
    chk("reset_phase", int'(sif.phase), 0);
    chk("reset_step", int'(sif.step), 0);
    chk("reset_running", int'(sif.running), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Forward, P=3 from phase 0.
    c0 = cyc;
    sif.period = 16'd3;
    sif.enable = 1'b1;
    push(3'd1, c0 + 4, 0);
    push(3'd2, c0 + 7, 0);
    push(3'd3, c0 + 10, 0);
    push(3'd4, c0 + 13, 0);
    push(3'd5, c0 + 16, 0);
    push(3'd0, c0 + 19, 1);
    push(3'd1, c0 + 22, 1);

    // Reverse through the 0 -> 5 wrap at P=1 (applies after the current phase).
    at_cyc(c0 + 22);
    sif.dir    = 1'b1;
    sif.period = 16'd1;
    push(3'd0, c0 + 25, 1);
    push(3'd5, c0 + 26, 0);
    push(3'd4, c0 + 27, 0);
    push(3'd3, c0 + 28, 0);
    at_cyc(c0 + 27);
    chk("step_held_p1", int'(sif.step), 1);

    // Forward at P=4, then P=2 requested two clocks into a phase.
    at_cyc(c0 + 28);
    sif.dir    = 1'b0;
    sif.period = 16'd4;
    push(3'd4, c0 + 29, 0);
    push(3'd5, c0 + 33, 0);
    push(3'd0, c0 + 35, 1);
    push(3'd1, c0 + 37, 1);
    at_cyc(c0 + 31);
    sif.period = 16'd2;

    // P=5, then enable drop before the step and resume.
    at_cyc(c0 + 37);
    sif.period = 16'd5;
    push(3'd2, c0 + 39, 1);
    at_cyc(c0 + 42);
    sif.enable = 1'b0;
    at_cyc(c0 + 46);
    chk("hold_phase", int'(sif.phase), 2);
    chk("hold_running", int'(sif.running), 0);
    chk("hold_step", int'(sif.step), 0);
    d = cyc;
    sif.enable = 1'b1;
    push(3'd3, d + 5, 1);
    push(3'd4, d + 10, 1);
    at_cyc(d + 1);
    chk("resume_running", int'(sif.running), 1);

    // Load coincident with a step event.
    at_cyc(d + 14);
    sif.load       = 1'b1;
    sif.load_phase = 3'd2;
    at_cyc(d + 15);
    chk("load_phase", int'(sif.phase), 2);
    chk("load_step", int'(sif.step), 0);
    sif.load = 1'b0;
    push(3'd3, d + 20, 1);

    // Out-of-range load value.
    at_cyc(d + 21);
    sif.load       = 1'b1;
    sif.load_phase = 3'd7;
    at_cyc(d + 22);
    chk("load_oob_phase", int'(sif.phase), 0);
    sif.load = 1'b0;
    push(3'd1, d + 27, 1);

    // Period 0 while running: current phase completes, then stepping stops.
    at_cyc(d + 28);
    sif.period = 16'd0;
    push(3'd2, d + 32, 1);
    at_cyc(d + 40);
    chk("p0_running", int'(sif.running), 0);
    chk("p0_phase", int'(sif.phase), 2);
    sif.period = 16'd1;
    push(3'd3, d + 42, 1);

    // Asynchronous reset mid-run with phase 3.
    at_cyc(d + 42);
    chk("pre_reset_phase", int'(sif.phase), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_phase", int'(sif.phase), 0);
    chk("async_reset_step", int'(sif.step), 0);
    chk("async_reset_running", int'(sif.running), 0);
`ifdef MBLDCM_PHASE_SEQUENCER_REVCNT_EN
    chk("async_reset_rev", int'(sif.rev_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    push(3'd1, r + 2, 0);
    at_cyc(r + 2);
    sif.enable = 1'b0;
    at_cyc(r + 5);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
